// File: rtl/stopwatch_up.sv
// stopwatch_up: BCD MM:SS up-counting stopwatch (tick/start_stop/lap/clear in; D3..D0, running, lapped, min_pulse, overflow out)
module stopwatch_up #(
  parameter bit WRAP = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic [3:0] D0,
  output logic [3:0] D1,
  output logic [3:0] D2,
  output logic [3:0] D3,
  output logic       running,
  output logic       lapped,
  output logic       min_pulse,
  output logic       overflow
);
  typedef enum logic [1:0] {IDLE, RUNNING, STOPPED} state_t;
  state_t state_q, state_d;
  logic [15:0] live_q, live_d, lap_q, lap_d, live_inc;
  logic lapped_q, lapped_d, ovf_q, ovf_d, minp_q, minp_d;
  logic c0, c1, c2, c3, lap_ok, zap;
  assign c0 = live_q[3:0] == 4'd9;
  assign c1 = c0 && live_q[7:4] == 4'd5;
  assign c2 = c1 && live_q[11:8] == 4'd9;
  assign c3 = c2 && live_q[15:12] == 4'd9;
  assign live_inc = {c2 ? (c3 ? 4'd0 : live_q[15:12] + 4'd1) : live_q[15:12],
                     c1 ? (c2 ? 4'd0 : live_q[11:8] + 4'd1) : live_q[11:8],
                     c0 ? (c1 ? 4'd0 : live_q[7:4] + 4'd1) : live_q[7:4],
                     c0 ? 4'd0 : live_q[3:0] + 4'd1};
  assign lap_ok = lap && !start_stop && !clear;
  assign zap = clear || (lap_ok && state_q == STOPPED && !lapped_q);
  always_comb begin
    state_d  = state_q;
    live_d   = live_q;
    lap_d    = lap_q;
    lapped_d = lapped_q;
    ovf_d    = ovf_q;
    minp_d   = 1'b0;
    if (start_stop && !clear)
      state_d = (state_q == RUNNING || (ovf_q && !WRAP)) ? STOPPED : RUNNING;
    if (lap_ok && state_q == RUNNING) begin
      lapped_d = !lapped_q;
      lap_d    = lapped_q ? lap_q : live_q;
    end
    if (lap_ok && state_q == STOPPED && lapped_q) lapped_d = 1'b0;
    if (tick && !clear && state_q == RUNNING) begin
      ovf_d  = ovf_q || c3;
      minp_d = c1 && (!c3 || WRAP);
      live_d = (c3 && !WRAP) ? live_q : live_inc;
      if (c3 && !WRAP) state_d = STOPPED;
    end
    if (zap) begin
      state_d  = IDLE;
      live_d   = '0;
      lap_d    = '0;
      lapped_d = 1'b0;
      ovf_d    = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      live_q   <= '0;
      lap_q    <= '0;
      lapped_q <= 1'b0;
      ovf_q    <= 1'b0;
      minp_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      live_q   <= live_d;
      lap_q    <= lap_d;
      lapped_q <= lapped_d;
      ovf_q    <= ovf_d;
      minp_q   <= minp_d;
    end
  end
  assign {D3, D2, D1, D0} = lapped_q ? lap_q : live_q;
  assign running   = state_q == RUNNING;
  assign lapped    = lapped_q;
  assign min_pulse = minp_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_stopwatch_up.sv
// tb_stopwatch_up: random + directed check of stopwatch_up (WRAP=0 and WRAP=1) against a seconds-based model
module tb_stopwatch_up;
  logic clk = 1'b0;
  logic reset = 1'b0, tick = 1'b0, start_stop = 1'b0, lap = 1'b0, clear = 1'b0;
  logic [3:0] a0, a1, a2, a3, b0, b1, b2, b3;
  logic ar, al, am, ao, br, bl, bm, bo;
  int tests = 0, fails = 0, mp_seen = 0;
  int sec [2];
  int lsec [2];
  bit run [2];
  bit lpd [2];
  bit ovf [2];
  bit mp [2];
  always #5 clk = ~clk;
  stopwatch_up #(.WRAP(1'b0)) u0 (
    .clk(clk), .reset(reset), .tick(tick), .start_stop(start_stop), .lap(lap), .clear(clear),
    .D0(a0), .D1(a1), .D2(a2), .D3(a3),
    .running(ar), .lapped(al), .min_pulse(am), .overflow(ao)
  );
  stopwatch_up #(.WRAP(1'b1)) u1 (
    .clk(clk), .reset(reset), .tick(tick), .start_stop(start_stop), .lap(lap), .clear(clear),
    .D0(b0), .D1(b1), .D2(b2), .D3(b3),
    .running(br), .lapped(bl), .min_pulse(bm), .overflow(bo)
  );
  function automatic logic [31:0] act(int w);
    return w == 1 ? {12'h0, b3, b2, b1, b0, br, bl, bm, bo}
                  : {12'h0, a3, a2, a1, a0, ar, al, am, ao};
  endfunction
  function automatic logic [31:0] expv(int w);
    int s, m, q;
    s = lpd[w] ? lsec[w] : sec[w];
    m = s / 60;
    q = s % 60;
    return {12'h0, 4'(m / 10), 4'(m % 10), 4'(q / 10), 4'(q % 10), run[w], lpd[w], mp[w], ovf[w]};
  endfunction
  task automatic check(string n, logic [31:0] got, logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %h want %h", n, got, want);
    end
  endtask
  task automatic clr(int w);
    sec[w] = 0; lsec[w] = 0; lpd[w] = 0; ovf[w] = 0; run[w] = 0;
  endtask
  always @(posedge clk) begin
    for (int w = 0; w < 2; w++) begin
      bit r;
      r = run[w];
      if (reset) begin
        clr(w);
        mp[w] = 0;
      end else begin
        mp[w] = 0;
        if (clear) clr(w);
        else begin
          if (start_stop) run[w] = r ? 1'b0 : !(ovf[w] && w == 0);
          else if (lap) begin
            if (r) begin
              if (lpd[w]) lpd[w] = 0;
              else begin lsec[w] = sec[w]; lpd[w] = 1; end
            end else if (lpd[w]) lpd[w] = 0;
            else clr(w);
          end
          if (tick && r) begin
            if (sec[w] == 5999) begin
              ovf[w] = 1;
              if (w == 1) begin sec[w] = 0; mp[w] = 1; end
              else run[w] = 0;
            end else begin
              if (sec[w] % 60 == 59) mp[w] = 1;
              sec[w]++;
            end
          end
        end
      end
    end
  end
  always @(posedge clk) begin
    #1;
    for (int w = 0; w < 2; w++) check($sformatf("cycle_w%0d", w), act(w), expv(w));
    if (am) mp_seen++;
  end
  task automatic cyc(bit t, bit ss, bit lp, bit cl, bit rs);
    tick = t; start_stop = ss; lap = lp; clear = cl; reset = rs;
    @(posedge clk);
    #2;
    tick = 0; start_stop = 0; lap = 0; clear = 0; reset = 0;
  endtask
  task automatic ticks(int n, int gap);
    repeat (n) begin
      cyc(1, 0, 0, 0, 0);
      repeat (gap) cyc(0, 0, 0, 0, 0);
    end
  endtask
  task automatic rnd(int n, int tk);
    repeat (n) cyc($urandom_range(0, 3) < tk, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                   $urandom_range(0, 63) == 0, $urandom_range(0, 255) == 0);
  endtask
  initial begin
    clr(0); clr(1); mp[0] = 0; mp[1] = 0;
    cyc(0, 0, 0, 0, 1);
    check("reset_w0", act(0), 32'h0);
    check("reset_w1", act(1), 32'h0);
    cyc(0, 1, 0, 0, 0);
    mp_seen = 0;
    ticks(75, 2);
    check("count_0115", act(0), {12'h0, 16'h0115, 4'b1000});
    check("one_min_pulse", 32'(mp_seen), 32'd1);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0);
    ticks(10, 2);
    check("at_0010", act(0), {12'h0, 16'h0010, 4'b1000});
    cyc(1, 1, 0, 0, 0);
    check("stop_with_tick", act(0), {12'h0, 16'h0011, 4'b0000});
    ticks(3, 1);
    check("stopped_hold", act(0), {12'h0, 16'h0011, 4'b0000});
    cyc(0, 1, 0, 0, 0);
    ticks(1, 1);
    check("resume_0012", act(0), {12'h0, 16'h0012, 4'b1000});
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0);
    ticks(20, 1);
    cyc(0, 0, 1, 0, 0);
    check("lap_freeze", act(0), {12'h0, 16'h0020, 4'b1100});
    ticks(5, 1);
    check("lap_frozen", act(0), {12'h0, 16'h0020, 4'b1100});
    cyc(0, 0, 1, 0, 0);
    check("lap_release", act(0), {12'h0, 16'h0025, 4'b1000});
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0);
    ticks(30, 1);
    cyc(0, 1, 0, 0, 0);
    check("stopped_0030", act(0), {12'h0, 16'h0030, 4'b0000});
    cyc(0, 0, 1, 0, 0);
    check("lap_stopped_idle", act(0), 32'h0);
    cyc(0, 0, 1, 0, 0);
    check("lap_idle_ignored", act(0), 32'h0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0);
    ticks(5998, 0);
    check("pre_9958_w0", act(0), {12'h0, 16'h9958, 4'b1000});
    check("pre_9958_w1", act(1), {12'h0, 16'h9958, 4'b1000});
    cyc(1, 0, 0, 0, 0);
    check("at_9959", act(0), {12'h0, 16'h9959, 4'b1000});
    cyc(1, 0, 0, 0, 0);
    check("saturate_w0", act(0), {12'h0, 16'h9959, 4'b0001});
    check("wrap_w1", act(1), {12'h0, 16'h0000, 4'b1011});
    cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("sat_start_ignored", act(0), {12'h0, 16'h9959, 4'b0001});
    cyc(0, 0, 0, 1, 0);
    check("clear_after_sat", act(0), 32'h0);
    cyc(0, 1, 0, 0, 0);
    ticks(754, 0);
    check("at_1234", act(0), {12'h0, 16'h1234, 4'b1000});
    cyc(1, 0, 1, 0, 1);
    check("reset_mid_w0", act(0), 32'h0);
    check("reset_mid_w1", act(1), 32'h0);
    rnd(3000, 2);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0);
    ticks(5990, 0);
    rnd(800, 3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
